// File: rtl/rfwb_pkg.sv
// Shared widths and the long-latency result entry type for the register-file
// write-side front end.
package rfwb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rfwb_entry_t;

endpackage

// File: rtl/rfwb_fifo.sv
// Synchronous DEPTH-entry FIFO of rfwb_entry_t; DEPTH must be a power of two
// so the pointers wrap by natural overflow.
module rfwb_fifo
    import rfwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  rfwb_entry_t din,
    input  logic        pop,
    output rfwb_entry_t dout,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    rfwb_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    // Requests against a full/empty FIFO are dropped here so callers need no guard.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Sole driver of the register file write port: merges pipeline writeback with
// queued long-latency results and tracks pending destinations. Optional
// feature macro: RFWB_DRAIN_STALL_EN (adds pipe_stall, drains a full FIFO first).
module regfile_writeback
    import rfwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lr_valid,
    output logic              lr_ready,
    input  logic [ADDR_W-1:0] lr_addr,
    input  logic [DATA_W-1:0] lr_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              we3,
    output logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] wd3,
    output logic [NREGS-1:0]  busy
`ifdef RFWB_DRAIN_STALL_EN
    ,
    output logic              pipe_stall
`endif
);

    // Long-latency handshake: a result transfers on any edge where
    // lr_valid && lr_ready; lr_ready depends only on registered FIFO state
    // (not full), and the producer holds lr_* stable while waiting.
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        wb_take;
    rfwb_entry_t head;
    rfwb_entry_t lr_entry;
    logic [NREGS-1:0] busy_next;

    assign lr_ready = !fifo_full;
    assign lr_entry = '{addr: lr_addr, data: lr_data};
    // Results for r0 complete the handshake but are never queued.
    assign push     = lr_valid && lr_ready && (lr_addr != REG_ZERO);

`ifdef RFWB_DRAIN_STALL_EN
    assign pipe_stall = fifo_full;
    assign wb_take    = wb_valid && (wb_addr != REG_ZERO) && !fifo_full;
`else
    assign wb_take    = wb_valid && (wb_addr != REG_ZERO);
`endif

    assign pop = !wb_take && !fifo_empty;

    rfwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (lr_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Address/data hold their last value on idle cycles; only we3 drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else begin
            we3 <= wb_take || pop;
            if (wb_take) begin
                a3  <= wb_addr;
                wd3 <= wb_data;
            end else if (pop) begin
                a3  <= head.addr;
                wd3 <= head.data;
            end
        end
    end

    // Clear on drain first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[head.addr] = 1'b0;
        end
        if (pend_set && (pend_addr != REG_ZERO)) begin
            busy_next[pend_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: queue-based reference model checked
// every cycle plus literal expectations at key points of each scenario.
module tb_regfile_writeback;
    import rfwb_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              lr_valid;
    logic              lr_ready;
    logic [ADDR_W-1:0] lr_addr;
    logic [DATA_W-1:0] lr_data;
    logic              pend_set;
    logic [ADDR_W-1:0] pend_addr;
    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;
    logic [NREGS-1:0]  busy;
`ifdef RFWB_DRAIN_STALL_EN
    logic              pipe_stall;
`endif

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .lr_valid  (lr_valid),
        .lr_ready  (lr_ready),
        .lr_addr   (lr_addr),
        .lr_data   (lr_data),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .busy      (busy)
`ifdef RFWB_DRAIN_STALL_EN
        ,
        .pipe_stall(pipe_stall)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a plain queue, busy a bit vector.
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [NREGS-1:0]  m_busy;
    logic              m_we;
    logic [ADDR_W-1:0] m_a3;
    logic [DATA_W-1:0] m_wd;
    bit                model_ok = 0;

    always @(posedge clk) begin : model
        logic [ADDR_W+DATA_W-1:0] e;
        bit room;
        bit take_wb;
        if (reset) begin
            exp_q.delete();
            m_busy   = '0;
            m_we     = 1'b0;
            m_a3     = '0;
            m_wd     = '0;
            model_ok = 1;
        end else begin
            room    = exp_q.size() < DEPTH;
            take_wb = wb_valid && (wb_addr != 0);
`ifdef RFWB_DRAIN_STALL_EN
            if (!room) take_wb = 0;
`endif
            m_we = 1'b0;
            if (take_wb) begin
                m_we = 1'b1;
                m_a3 = wb_addr;
                m_wd = wb_data;
            end else if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                m_we = 1'b1;
                m_a3 = e[ADDR_W+DATA_W-1:DATA_W];
                m_wd = e[DATA_W-1:0];
                m_busy[m_a3] = 1'b0;
            end
            if (lr_valid && room && (lr_addr != 0)) exp_q.push_back({lr_addr, lr_data});
            if (pend_set && (pend_addr != 0)) m_busy[pend_addr] = 1'b1;
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            chk("cyc_we3",      64'(we3),      64'(m_we));
            chk("cyc_a3",       64'(a3),       64'(m_a3));
            chk("cyc_wd3",      64'(wd3),      64'(m_wd));
            chk("cyc_busy",     64'(busy),     64'(m_busy));
            chk("cyc_lr_ready", 64'(lr_ready), 64'(exp_q.size() < DEPTH));
`ifdef RFWB_DRAIN_STALL_EN
            chk("cyc_pipe_stall", 64'(pipe_stall), 64'(exp_q.size() == DEPTH));
`endif
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_addr = '0; wb_data = '0;
        lr_valid = 0; lr_addr = '0; lr_data = '0;
        pend_set = 0; pend_addr = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        // Reset state
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_a3", 64'(a3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_lr_ready", 64'(lr_ready), 64'd1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_we3", 64'(we3), 64'd0);
        end

        // Pipeline only
        wb_valid = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        chk("wb_we3", 64'(we3), 64'd1);
        chk("wb_a3", 64'(a3), 64'd5);
        chk("wb_wd3", 64'(wd3), 64'hDEADBEEF);
        idle_inputs();
        step();
        chk("wb_we3_drop", 64'(we3), 64'd0);
        chk("wb_a3_hold", 64'(a3), 64'd5);

        // Conflict: pend r9, then lr r9 with wb r3 in the same cycle
        pend_set = 1; pend_addr = 5'd9;
        step();
        pend_set = 0;
        step();
        chk("cf_busy9_set", 64'(busy[9]), 64'd1);
        wb_valid = 1; wb_addr = 5'd3; wb_data = 32'h0000AAAA;
        lr_valid = 1; lr_addr = 5'd9; lr_data = 32'h00001234;
        step();
        chk("cf_a3_wb", 64'(a3), 64'd3);
        chk("cf_wd3_wb", 64'(wd3), 64'h0000AAAA);
        chk("cf_busy9_held", 64'(busy[9]), 64'd1);
        idle_inputs();
        step();
        chk("cf_a3_lr", 64'(a3), 64'd9);
        chk("cf_wd3_lr", 64'(wd3), 64'h00001234);
        chk("cf_busy9_clr", 64'(busy[9]), 64'd0);
        step();

        // Full / wrap, two rounds
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int i = 0; i < 4; i++) begin
                wb_valid = 1; wb_addr = 5'(10 + i); wb_data = 32'(32'h5000 + i);
                lr_valid = 1; lr_addr = 5'(i + 1); lr_data = 32'(rnd * 256 + i);
                step();
            end
            chk("full_lr_ready", 64'(lr_ready), 64'd0);
            wb_addr = 5'd14; lr_addr = 5'd5; lr_data = 32'(rnd * 256 + 4);
            step();
`ifndef RFWB_DRAIN_STALL_EN
            chk("full_still", 64'(lr_ready), 64'd0);
            chk("full_wb_a3", 64'(a3), 64'd14);
`endif
            wb_valid = 0;
            step();
`ifndef RFWB_DRAIN_STALL_EN
            chk("drain_a3_r1", 64'(a3), 64'd1);
            chk("drain_wd3_r1", 64'(wd3), 64'(rnd * 256));
            chk("drain_lr_ready", 64'(lr_ready), 64'd1);
`endif
            step();
            lr_valid = 0;
`ifndef RFWB_DRAIN_STALL_EN
            chk("drain_a3_r2", 64'(a3), 64'd2);
`endif
            for (int k = 0; k < 4; k++) step();
            idle_inputs();
            step();
            chk("drain_done_we3", 64'(we3), 64'd0);
        end

        // r0 handling
        wb_valid = 1; wb_addr = 5'd2; wb_data = 32'h22;
        lr_valid = 1; lr_addr = 5'd7; lr_data = 32'h77;
        step();
        lr_valid = 0;
        wb_addr = 5'd0; wb_data = 32'h99;
        step();
        chk("r0_wb_a3", 64'(a3), 64'd7);
        chk("r0_wb_wd3", 64'(wd3), 64'h77);
        idle_inputs();
        lr_valid = 1; lr_addr = 5'd0; lr_data = 32'hFFFFFFFF;
        step();
        chk("r0_lr_ready", 64'(lr_ready), 64'd1);
        lr_valid = 0;
        step();
        chk("r0_lr_nowrite", 64'(we3), 64'd0);
        pend_set = 1; pend_addr = 5'd0;
        step();
        pend_set = 0;
        step();
        chk("r0_busy", 64'(busy), 64'd0);

        // Reset with three queued entries
        for (int i = 1; i <= 3; i++) begin
            wb_valid = 1; wb_addr = 5'd4; wb_data = 32'(i);
            lr_valid = 1; lr_addr = 5'(i); lr_data = 32'(32'h300 + i);
            pend_set = 1; pend_addr = 5'(i);
            step();
        end
        idle_inputs();
        chk("mid_busy_pre", 64'(busy), 64'h0000000E);
        reset = 1;
        step();
        reset = 0;
        step();
        chk("mid_we3", 64'(we3), 64'd0);
        chk("mid_lr_ready", 64'(lr_ready), 64'd1);
        chk("mid_busy", 64'(busy), 64'd0);
        step();
        chk("mid_we3_after", 64'(we3), 64'd0);

`ifdef RFWB_DRAIN_STALL_EN
        // Drain stall: full FIFO overrides a held pipeline request
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1; wb_addr = 5'd20; wb_data = 32'h2020;
            lr_valid = 1; lr_addr = 5'(i); lr_data = 32'(32'h50 + i);
            step();
        end
        lr_valid = 0;
        chk("ds_stall_on", 64'(pipe_stall), 64'd1);
        step();
        chk("ds_head_a3", 64'(a3), 64'd1);
        chk("ds_head_wd3", 64'(wd3), 64'h51);
        chk("ds_stall_off", 64'(pipe_stall), 64'd0);
        step();
        chk("ds_wb_a3", 64'(a3), 64'd20);
        chk("ds_wb_wd3", 64'(wd3), 64'h2020);
        idle_inputs();
        for (int k = 0; k < 4; k++) step();
`endif

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
